fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch sequencer states (BOOT, RUN, MEM_WAIT)
//   NOP_INSTR     : encoding loaded into IF/ID for an empty slot
//   INSTR_BYTES   : PC increment per sequential instruction
//   align_word    : clears the byte-offset bits of an address
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register between fetch and decode.
//   clk, rst_n              : clock, asynchronous active-low reset
//   load                    : capture the next_* inputs this edge
//   flush                   : nullify the slot; wins over load and over hold
//   next_instr/pc/valid     : candidate contents from the fetch stage
//   instr, pc, valid        : registered slot seen by decode
// A slot whose valid bit is 0 always carries NOP_INSTR, so decode never
// sees stale or undefined instruction bits.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] next_instr,
  input  logic [DATA_W-1:0] next_pc,
  input  logic              next_valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc,
  output logic              valid
);

  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_W;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      // PC field is left alone: with valid=0 it carries no meaning.
      instr <= NOP_W;
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_valid ? next_instr : NOP_W;
      pc    <= next_pc;
      valid <= next_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PA-RISC style delayed branching.
//   RESET_PC    : PC loaded on reset (nPC = RESET_PC + 4)
//   clk, rst_n  : clock, asynchronous active-low reset
//   IMEM_ADDR   : instruction memory byte address (= PC)
//   IMEM_REQ    : fetch request, high in RUN and MEM_WAIT
//   IMEM_DATA   : fetched instruction word
//   IMEM_VALID  : IMEM_DATA is valid for IMEM_ADDR
//   LE          : PC and IF/ID load enable from hazard unit (0 = stall)
//   BT, TA      : branch taken and target from execute (TA[1:0] ignored)
//   FLUSH       : nullify the IF/ID slot
//   IF_ID_*     : registered instruction, its PC, and its valid flag
// The instruction at nPC always issues after a branch (delay slot), so a
// taken branch only redirects nPC. A branch arriving while the fetch cannot
// advance is parked in a pending-target register until the next advance.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_REQ,
  input  logic [31:0] IMEM_DATA,
  input  logic        IMEM_VALID,
  input  logic        LE,
  input  logic        BT,
  input  logic [31:0] TA,
  input  logic        FLUSH,
  output logic [31:0] IF_ID_INSTR,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_VALID
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, npc;
  logic         pend;
  logic [31:0]  pend_target;

  logic         active;
  logic         advance;
  logic [31:0]  bt_target;
  logic         br_taken;
  logic [31:0]  br_target;
  logic         slot_load;

  assign active    = (state == RUN) || (state == MEM_WAIT);
  assign advance   = active && IMEM_VALID && LE;
  assign bt_target = align_word(TA);

  // A branch reported on the advancing edge is newer than anything pending.
  assign br_taken  = BT || pend;
  assign br_target = BT ? bt_target : pend_target;

  assign IMEM_ADDR = pc;

  // IF/ID is written whenever the stage is running and not stalled; a
  // missing memory response loads a bubble rather than holding old data.
  assign slot_load = active && LE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    IMEM_REQ   = 1'b0;
    case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        IMEM_REQ = 1'b1;
        if (LE && !IMEM_VALID) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        IMEM_REQ = 1'b1;
        if (advance) state_next = RUN;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // ---- PC / nPC / pending branch ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      npc         <= RESET_PC + INSTR_BYTES;
      pend        <= 1'b0;
      pend_target <= '0;
    end else if (advance) begin
      pc   <= npc;
      npc  <= br_taken ? br_target : npc + INSTR_BYTES;
      pend <= 1'b0;
    end else if (BT) begin
      pend        <= 1'b1;
      pend_target <= bt_target;
    end
  end

  // ---- IF/ID boundary ----
  if_id_reg #(
    .DATA_W (32)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (slot_load),
    .flush      (FLUSH),
    .next_instr (IMEM_DATA),
    .next_pc    (pc),
    .next_valid (IMEM_VALID),
    .instr      (IF_ID_INSTR),
    .pc         (IF_ID_PC),
    .valid      (IF_ID_VALID)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        le;
  logic        bt;
  logic [31:0] ta;
  logic        flush;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IMEM_ADDR   (imem_addr),
    .IMEM_REQ    (imem_req),
    .IMEM_DATA   (imem_data),
    .IMEM_VALID  (imem_valid),
    .LE          (le),
    .BT          (bt),
    .TA          (ta),
    .FLUSH       (flush),
    .IF_ID_INSTR (if_id_instr),
    .IF_ID_PC    (if_id_pc),
    .IF_ID_VALID (if_id_valid)
  );

  // Memory model: every address holds a distinct, nonzero word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  // Scoreboard monitor: a fetch handshake at a rising edge must deliver the
  // oldest expected address into IF/ID on that edge.
  always @(posedge clk) begin : monitor
    logic        hs;
    logic        fl;
    logic [31:0] e;
    hs = rst_n && imem_req && imem_valid && le;
    fl = flush;
    if (hs) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected: got IF_ID_PC=%h, required no fetch", if_id_pc);
      end else begin
        e = exp_q.pop_front();
        if (fl) begin
          if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_flushed: got instr=%h valid=%b, required 0/0", if_id_instr, if_id_valid);
          end
        end else if (if_id_pc !== e || if_id_instr !== mem_word(e) || if_id_valid !== 1'b1) begin
          errors++;
          $display("FAIL fetch_slot: got pc=%h instr=%h valid=%b, required pc=%h instr=%h valid=1",
                   if_id_pc, if_id_instr, if_id_valid, e, mem_word(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; le = 1'b1; imem_valid = 1'b1; bt = 1'b0; ta = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h, required 0", imem_addr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, required 0", imem_req); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h, required 0", if_id_instr); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h, required 0", if_id_pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", if_id_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b, required 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL run_req: got %b, required 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL run_addr: got %h, required 0", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL run_valid: got %b, required 0", if_id_valid); end
  endtask

  task automatic test_sequential();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr: got %h, required %h", imem_addr, 32'(4 * i)); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] a[4];
    a = '{32'h0000_000C, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    bt = 1'b1; ta = 32'h0000_0103;
    for (int i = 0; i < 4; i++) begin
      tick();
      bt = 1'b0; ta = '0;
      checks++;
      if (imem_addr !== a[i]) begin errors++; $display("FAIL branch_addr: got %h, required %h", imem_addr, a[i]); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL branch_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic [31:0] a[4];
    a = '{32'h0000_010C, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
    le = 1'b0; bt = 1'b1; ta = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      tick();
      bt = 1'b0; ta = '0;
      checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL stall_addr: got %h, required 108", imem_addr); end
      checks++; if (if_id_pc !== 32'h104) begin errors++; $display("FAIL stall_pc: got %h, required 104", if_id_pc); end
      checks++; if (if_id_instr !== mem_word(32'h104)) begin errors++; $display("FAIL stall_instr: got %h, required %h", if_id_instr, mem_word(32'h104)); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b, required 1", if_id_valid); end
    end
    le = 1'b1;
    exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (imem_addr !== a[i]) begin errors++; $display("FAIL stall_resume_addr: got %h, required %h", imem_addr, a[i]); end
    end
  endtask

  task automatic test_pending_overwrite();
    imem_valid = 1'b0; bt = 1'b1; ta = 32'h0000_0300;
    tick();
    checks++; if (imem_addr !== 32'h208) begin errors++; $display("FAIL pend_addr: got %h, required 208", imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL pend_bubble: got instr=%h valid=%b, required 0/0", if_id_instr, if_id_valid); end
    checks++; if (dut.state !== MEM_WAIT) begin errors++; $display("FAIL pend_state: got %0d, required %0d", dut.state, MEM_WAIT); end
    ta = 32'h0000_0010;
    tick();
    bt = 1'b0; ta = '0; imem_valid = 1'b1;
    exp_q.push_back(32'h208);
    exp_q.push_back(32'h20C);
    tick();
    checks++; if (imem_addr !== 32'h20C) begin errors++; $display("FAIL pend_slot_addr: got %h, required 20c", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL pend_target_addr: got %h, required 10", imem_addr); end
  endtask

  task automatic test_mem_wait();
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL wait_addr: got %h, required 10", imem_addr); end
      checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL wait_bubble: got instr=%h valid=%b, required 0/0", if_id_instr, if_id_valid); end
      checks++; if (dut.state !== MEM_WAIT) begin errors++; $display("FAIL wait_state: got %0d, required %0d", dut.state, MEM_WAIT); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req: got %b, required 1", imem_req); end
    end
    imem_valid = 1'b1;
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    tick();
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL wait_resume_addr: got %h, required 14", imem_addr); end
    checks++; if (dut.state !== RUN) begin errors++; $display("FAIL wait_resume_state: got %0d, required %0d", dut.state, RUN); end
    tick();
    checks++; if (imem_addr !== 32'h18) begin errors++; $display("FAIL wait_next_addr: got %h, required 18", imem_addr); end
  endtask

  task automatic test_flush();
    le = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_slot: got instr=%h valid=%b, required 0/0", if_id_instr, if_id_valid); end
    checks++; if (imem_addr !== 32'h18) begin errors++; $display("FAIL flush_addr: got %h, required 18", imem_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_hold_valid: got %b, required 0", if_id_valid); end
    checks++; if (imem_addr !== 32'h18) begin errors++; $display("FAIL flush_hold_addr: got %h, required 18", imem_addr); end
    le = 1'b1;
    exp_q.push_back(32'h18);
    tick();
    checks++; if (imem_addr !== 32'h1C) begin errors++; $display("FAIL flush_resume_addr: got %h, required 1c", imem_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] a[5];
    a = '{32'h0000_0020, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    exp_q.push_back(32'h1C);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    bt = 1'b1; ta = 32'hFFFF_FFF8;
    for (int i = 0; i < 5; i++) begin
      tick();
      bt = 1'b0; ta = '0;
      checks++;
      if (imem_addr !== a[i]) begin errors++; $display("FAIL wrap_addr: got %h, required %h", imem_addr, a[i]); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_wait();
    imem_valid = 1'b0;
    tick();
    checks++; if (dut.state !== MEM_WAIT) begin errors++; $display("FAIL mid_state: got %0d, required %0d", dut.state, MEM_WAIT); end
    checks++; if (if_id_pc !== 32'h4) begin errors++; $display("FAIL mid_pc_pre: got %h, required 4", if_id_pc); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL async_addr: got %h, required 0", imem_addr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_req: got %b, required 0", imem_req); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL async_instr: got %h, required 0", if_id_instr); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL async_pc: got %h, required 0", if_id_pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b, required 0", if_id_valid); end
    imem_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL restart_run: got addr=%h req=%b, required 0/1", imem_addr, imem_req); end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    tick();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL restart_addr: got %h, required 8", imem_addr); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_pending_overwrite();
    test_mem_wait();
    test_flush();
    test_wrap();
    test_reset_mid_wait();
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
